// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types.
//   regbits_t  - register-file index (5 bits)
//   hzstate_t  - hazard controller sequencing state
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hzstate_t;

endpackage

// File: rtl/perf_counter.sv
// perf_counter: saturating event counter.
//   CLK, nRST  - clock, asynchronous active-low reset (clears count)
//   inc        - count this cycle
//   freeze     - hold the count regardless of inc
//   cnt        - current count, sticks at all-ones
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (inc && !freeze && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: enable/flush sequencing for the five-stage pipeline.
//   Inputs : ihit, dhit, mem_dren/mem_dwen (EX/MEM access), ex_memread/ex_wsel
//            (ID/EX load), id_rs/id_rt/id_halt (IF/ID), ex_pcsrc, wb_halt.
//   Outputs: pc/ifid/idex/exmem/memwb enables, ifid/idex/memwb flushes,
//            halt and mem_timeout (registered), cyc/stall/flush counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             ex_memread,
    input  regbits_t         ex_wsel,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_halt,
    input  logic             ex_pcsrc,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    hzstate_t          state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dstall;
    logic              load_use;
    logic              stall_ev;
    logic              flush_ev;
    logic              halted;

    assign halted = (state == HALTED);

    // Priority resolution; first matching rule wins.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        next_state  = state;

        // A dhit in DWAIT satisfies the access, so DWAIT and RUN share the same rules.
        dstall   = (mem_dren | mem_dwen) & ~dhit;
        load_use = ex_memread && (ex_wsel != '0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));

        if (halted) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            dstall   = 1'b0;
        end else begin
            next_state = dstall ? DWAIT : RUN;
            if (dstall) begin
                // Freeze everything upstream of MEM/WB; bubble into WB.
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
                stall_ev    = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                stall_ev   = 1'b1;
            end else if (ex_pcsrc) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flush_ev   = 1'b1;
            end else if (id_halt || !ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                stall_ev   = 1'b1;
            end
            if (wb_halt) begin
                next_state = HALTED;
            end
        end
    end

    // wait_cnt counts consecutive data-cache stall cycles, including the one that enters DWAIT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            wait_cnt    <= '0;
            halt        <= 1'b0;
            mem_timeout <= 1'b0;
        end else if (!halted) begin
            state <= next_state;
            if (wb_halt) begin
                halt <= 1'b1;
            end
            if (dstall) begin
                if (wait_cnt != WAIT_W'(WAIT_MAX)) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt >= WAIT_W'(WAIT_MAX - 1)) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_cyc_cnt (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (1'b1),
        .freeze (halted),
        .cnt    (cyc_cnt)
    );

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (stall_ev),
        .freeze (halted),
        .cnt    (stall_cnt)
    );

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (flush_ev),
        .freeze (halted),
        .cnt    (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of the hazard controller with
// CNT_W=4 and WAIT_MAX=8 so saturation and timeout are reachable quickly.
module tb_pipeline_hazard_ctrl;
    import cpu_types_pkg::*;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WAIT_MAX = 8;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, mem_dren, mem_dwen, ex_memread, id_halt, ex_pcsrc, wb_halt;
    regbits_t         ex_wsel, id_rs, id_rt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, memwb_flush;
    logic             halt, mem_timeout;
    logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

    logic [4:0]       en;
    logic [2:0]       fl;
    int               n_cmp = 0;
    int               n_err = 0;

    assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fl = {ifid_flush, idex_flush, memwb_flush};

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(
        .CNT_W    (CNT_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .mem_dren    (mem_dren),
        .mem_dwen    (mem_dwen),
        .ex_memread  (ex_memread),
        .ex_wsel     (ex_wsel),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_halt     (id_halt),
        .ex_pcsrc    (ex_pcsrc),
        .wb_halt     (wb_halt),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .memwb_flush (memwb_flush),
        .halt        (halt),
        .mem_timeout (mem_timeout),
        .cyc_cnt     (cyc_cnt),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
        ex_memread = 1'b0; ex_wsel = '0; id_rs = '0; id_rt = '0;
        id_halt = 1'b0; ex_pcsrc = 1'b0; wb_halt = 1'b0;
    endtask

    // Reset pulse between negedge and the following posedge.
    task automatic do_reset();
        clr_inputs();
        @(negedge CLK);
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b1;
        clr_inputs();

        // Reset / idle
        do_reset();
        #1;
        check("rst_en", 32'(en), 32'h1f);
        check("rst_fl", 32'(fl), 32'h0);
        check("rst_halt", 32'(halt), 32'h0);
        check("rst_tmo", 32'(mem_timeout), 32'h0);
        check("rst_cyc", 32'(cyc_cnt), 32'h0);
        repeat (10) tick();
        check("idle_cyc10", 32'(cyc_cnt), 32'd10);
        check("idle_stall0", 32'(stall_cnt), 32'd0);

        // Load-use on rs, then load moves to EX/MEM
        do_reset();
        ex_memread = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5;
        #1;
        check("lu_en", 32'(en), 32'h07);
        check("lu_fl", 32'(fl), 32'h2);
        tick();
        check("lu_stall1", 32'(stall_cnt), 32'd1);
        ex_memread = 1'b0; mem_dren = 1'b1; dhit = 1'b1;
        #1;
        check("lu_after_en", 32'(en), 32'h1f);
        check("lu_after_fl", 32'(fl), 32'h0);
        tick();
        check("lu_after_stall", 32'(stall_cnt), 32'd1);
        clr_inputs();
        ex_memread = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0;
        #1;
        check("lu_r0_en", 32'(en), 32'h1f);
        ex_wsel = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
        #1;
        check("lu_rt_en", 32'(en), 32'h07);

        // Branch, branch under dcache miss, branch with load-use
        do_reset();
        ex_pcsrc = 1'b1;
        #1;
        check("br_en", 32'(en), 32'h1f);
        check("br_fl", 32'(fl), 32'h6);
        tick();
        check("br_flush1", 32'(flush_cnt), 32'd1);
        mem_dren = 1'b1; dhit = 1'b0;
        #1;
        check("br_dw_en", 32'(en), 32'h01);
        check("br_dw_fl", 32'(fl), 32'h1);
        tick();
        check("br_dw_flush", 32'(flush_cnt), 32'd1);
        check("br_dw_stall", 32'(stall_cnt), 32'd1);
        mem_dren = 1'b0; ex_memread = 1'b1; ex_wsel = 5'd4; id_rs = 5'd4;
        #1;
        check("br_lu_en", 32'(en), 32'h07);
        check("br_lu_fl", 32'(fl), 32'h2);
        tick();
        check("br_lu_stall", 32'(stall_cnt), 32'd2);
        check("br_lu_flush", 32'(flush_cnt), 32'd1);

        // Data wait for 4 cycles, then hit (store path)
        do_reset();
        mem_dwen = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("dw_en%0d", i), 32'(en), 32'h01);
            check($sformatf("dw_fl%0d", i), 32'(fl), 32'h1);
            tick();
        end
        dhit = 1'b1;
        #1;
        check("dw_hit_en", 32'(en), 32'h1f);
        check("dw_hit_fl", 32'(fl), 32'h0);
        tick();
        check("dw_stall4", 32'(stall_cnt), 32'd4);

        // Timeout after WAIT_MAX consecutive wait cycles, sticky
        do_reset();
        mem_dren = 1'b1; dhit = 1'b0;
        repeat (7) tick();
        check("tmo_7", 32'(mem_timeout), 32'h0);
        tick();
        check("tmo_8", 32'(mem_timeout), 32'h1);
        dhit = 1'b1;
        repeat (2) tick();
        check("tmo_sticky", 32'(mem_timeout), 32'h1);

        // id_halt, icache miss, then wb_halt
        do_reset();
        id_halt = 1'b1;
        #1;
        check("idh_en", 32'(en), 32'h0f);
        check("idh_fl", 32'(fl), 32'h4);
        tick();
        id_halt = 1'b0; ihit = 1'b0;
        #1;
        check("imiss_en", 32'(en), 32'h0f);
        check("imiss_fl", 32'(fl), 32'h4);
        tick();
        ihit = 1'b1; wb_halt = 1'b1;
        #1;
        check("wbh_pre_halt", 32'(halt), 32'h0);
        tick();
        wb_halt = 1'b0;
        check("wbh_halt", 32'(halt), 32'h1);
        check("wbh_en", 32'(en), 32'h00);
        check("wbh_fl", 32'(fl), 32'h0);
        ex_memread = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3;
        #1;
        check("hlt_lu_en", 32'(en), 32'h00);
        repeat (5) tick();
        check("hlt_cyc", 32'(cyc_cnt), 32'd3);
        check("hlt_stall", 32'(stall_cnt), 32'd2);
        check("hlt_still", 32'(halt), 32'h1);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        clr_inputs();
        #1;
        check("hlt_rst_halt", 32'(halt), 32'h0);
        check("hlt_rst_cyc", 32'(cyc_cnt), 32'd0);
        check("hlt_rst_en", 32'(en), 32'h1f);
        nRST = 1'b1;

        // wb_halt while in DWAIT
        do_reset();
        mem_dren = 1'b1; dhit = 1'b0;
        tick();
        wb_halt = 1'b1;
        tick();
        check("dwh_halt", 32'(halt), 32'h1);
        clr_inputs();
        #1;
        check("dwh_en", 32'(en), 32'h00);

        // Async reset mid-DWAIT
        do_reset();
        mem_dren = 1'b1; dhit = 1'b0;
        repeat (2) tick();
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("dw_rst_stall", 32'(stall_cnt), 32'd0);
        check("dw_rst_cyc", 32'(cyc_cnt), 32'd0);
        nRST = 1'b1;

        // Saturation at 4 bits
        do_reset();
        ex_memread = 1'b1; ex_wsel = 5'd9; id_rt = 5'd9;
        repeat (20) tick();
        check("sat_stall", 32'(stall_cnt), 32'd15);
        check("sat_cyc", 32'(cyc_cnt), 32'd15);
        repeat (3) tick();
        check("sat_hold", 32'(stall_cnt), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
